// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and stream framing constants for imem_loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - gathers four bytes MSB-first into one 32-bit word
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0]  cnt;
    logic [23:0] sr;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
            sr  <= '0;
        end else if (push) begin
            cnt <= cnt + 2'd1;
            sr  <= {sr[15:0], data};
        end
    end

    // The completing byte is merged combinationally so the word is usable on its handshake.
    assign word      = {sr, data};
    assign word_full = push && (cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte stream to instruction memory loader; option IMEM_LOADER_CHECKSUM_EN
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

    // Words that fit between BASE_ADDR and the top of memory; larger images are refused.
    localparam int CAP_WORDS = (1 << (ADDR_W - 2)) - BASE_ADDR / WORD_BYTES;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_LAST = CSUM;
`else
    localparam state_t AFTER_LAST = DONE;
`endif

    state_t state, state_nx;

    logic [8*(HDR_BYTES-1)-1:0] hdr_hi;
    logic [8*HDR_BYTES-1:0]     hdr_len;
    logic [15:0]                remaining;
    logic                       take;
    logic                       start_ok;
    logic                       push;
    logic [31:0]                pk_word;
    logic                       pk_full;

    assign take     = in_valid && in_ready;
    assign start_ok = start && (state == IDLE || state == DONE || state == ERROR);
    assign push     = take && (state == DATA);
    assign hdr_len  = {hdr_hi, in_data};

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            csum <= '0;
        end else if (push) begin
            csum <= csum ^ in_data;
        end
    end
`endif

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .push      (push),
        .data      (in_data),
        .word      (pk_word),
        .word_full (pk_full)
    );

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = HDR_HI;
            end
            HDR_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = HDR_LO;
            end
            HDR_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (hdr_len == '0)                      state_nx = AFTER_LAST;
                    else if (int'(hdr_len) > CAP_WORDS)     state_nx = ERROR;
                    else                                    state_nx = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (pk_full) state_nx = WRITE;
            end
            WRITE: begin
                state_nx = (remaining == 16'd1) ? AFTER_LAST : DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = (in_data == csum) ? DONE : ERROR;
            end
`endif
            DONE, ERROR: begin
                if (start) state_nx = HDR_HI;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            hdr_hi       <= '0;
            remaining    <= '0;
            im_addr      <= ADDR_W'(BASE_ADDR);
            im_wdata     <= '0;
            words_loaded <= '0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                im_addr      <= ADDR_W'(BASE_ADDR);
                words_loaded <= '0;
            end
            if (take && state == HDR_HI) hdr_hi <= in_data;
            if (take && state == HDR_LO) remaining <= hdr_len;
            if (pk_full) im_wdata <= pk_word;
            if (state == WRITE) begin
                im_addr      <= im_addr + ADDR_W'(WORD_BYTES);
                words_loaded <= words_loaded + 16'd1;
                remaining    <= remaining - 16'd1;
            end
        end
    end

    assign im_we    = (state == WRITE);
    assign done     = (state == DONE);
    assign err      = (state == ERROR);
    assign cpu_hold = (state != DONE);

endmodule
